// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: configurable data width, parity and stop bits,
// 3-sample majority vote at bit centre, parity/framing/break status per word.
//
// state    | meaning
// S_IDLE   | line idle, waiting for rx_s low
// S_START  | validating start bit at half-bit point
// S_DATA   | sampling data bits LSB first
// S_PARITY | sampling parity bit
// S_STOP   | sampling stop bit(s), publishing the word on the last one
// S_BRK    | framing error seen, waiting for line to return high
module uart_rx_param #(
    parameter int OVERSAMPLE = 16,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic                 Bclk,
    input  logic                 reset_n,
    input  logic                 rx_data,
    output logic                 rx_valid,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 break_det,
    output logic                 busy
);
    localparam int SW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(DATA_BITS + 1);
    localparam logic [SW-1:0] C_HALF    = SW'(OVERSAMPLE / 2 - 1);
    localparam logic [SW-1:0] C_FULL    = SW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] LAST_DATA = BW'(DATA_BITS - 1);
    localparam logic [BW-1:0] LAST_STOP = BW'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP,
        S_BRK
    } state_t;

    state_t               state_q, state_d;
    logic                 sync1_q, sync1_d;
    logic                 rx_s_q, rx_s_d;
    logic [1:0]           hist_q, hist_d;
    logic [SW-1:0]        sample_cnt_q, sample_cnt_d;
    logic [BW-1:0]        bit_cnt_q, bit_cnt_d;
    logic [DATA_BITS-1:0] shreg_q, shreg_d;
    logic                 par_bit_q, par_bit_d;
    logic                 par_acc_q, par_acc_d;
    logic                 fe_acc_q, fe_acc_d;
    logic                 rx_valid_q, rx_valid_d;
    logic [DATA_BITS-1:0] data_out_q, data_out_d;
    logic                 parity_err_q, parity_err_d;
    logic                 frame_err_q, frame_err_d;
    logic                 break_det_q, break_det_d;
    logic                 busy_q, busy_d;

    logic                 vote;
    logic                 at_dec;
    logic                 fe_now;

    // hist_q holds rx_s from the two edges before the decision edge
    assign vote   = (hist_q[1] & hist_q[0]) | (hist_q[1] & rx_s_q) | (hist_q[0] & rx_s_q);
    assign at_dec = (sample_cnt_q == ((state_q == S_START) ? C_HALF : C_FULL));

    always_comb begin
        sync1_d      = rx_data;
        rx_s_d       = sync1_q;
        hist_d       = {hist_q[0], rx_s_q};
        state_d      = state_q;
        sample_cnt_d = sample_cnt_q + 1'b1;
        bit_cnt_d    = bit_cnt_q;
        shreg_d      = shreg_q;
        par_bit_d    = par_bit_q;
        par_acc_d    = par_acc_q;
        fe_acc_d     = fe_acc_q;
        rx_valid_d   = 1'b0;
        data_out_d   = data_out_q;
        parity_err_d = parity_err_q;
        frame_err_d  = frame_err_q;
        break_det_d  = break_det_q;
        fe_now       = fe_acc_q;

        case (state_q)
            S_IDLE: begin
                sample_cnt_d = '0;
                if (!rx_s_q) begin
                    state_d   = S_START;
                    bit_cnt_d = '0;
                    par_bit_d = 1'b0;
                    par_acc_d = 1'b0;
                    fe_acc_d  = 1'b0;
                end
            end
            S_START: begin
                if (at_dec) begin
                    sample_cnt_d = '0;
                    state_d      = vote ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                if (at_dec) begin
                    sample_cnt_d = '0;
                    shreg_d      = {vote, shreg_q[DATA_BITS-1:1]};
                    if (bit_cnt_q == LAST_DATA) begin
                        bit_cnt_d = '0;
                        state_d   = (PARITY != 0) ? S_PARITY : S_STOP;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end
            end
            S_PARITY: begin
                if (at_dec) begin
                    sample_cnt_d = '0;
                    par_bit_d    = vote;
                    par_acc_d    = ((^shreg_q) ^ vote) != (PARITY == 1);
                    state_d      = S_STOP;
                end
            end
            S_STOP: begin
                if (at_dec) begin
                    sample_cnt_d = '0;
                    fe_now       = fe_acc_q | ~vote;
                    fe_acc_d     = fe_now;
                    if (bit_cnt_q == LAST_STOP) begin
                        rx_valid_d   = 1'b1;
                        data_out_d   = shreg_q;
                        parity_err_d = par_acc_q;
                        frame_err_d  = fe_now;
                        break_det_d  = fe_now && (shreg_q == '0) && !par_bit_q;
                        state_d      = fe_now ? S_BRK : S_IDLE;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end
            end
            S_BRK: begin
                sample_cnt_d = '0;
                if (rx_s_q) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge Bclk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= S_IDLE;
            sync1_q      <= 1'b1;
            rx_s_q       <= 1'b1;
            hist_q       <= 2'b11;
            sample_cnt_q <= '0;
            bit_cnt_q    <= '0;
            shreg_q      <= '0;
            par_bit_q    <= 1'b0;
            par_acc_q    <= 1'b0;
            fe_acc_q     <= 1'b0;
            rx_valid_q   <= 1'b0;
            data_out_q   <= '0;
            parity_err_q <= 1'b0;
            frame_err_q  <= 1'b0;
            break_det_q  <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            sync1_q      <= sync1_d;
            rx_s_q       <= rx_s_d;
            hist_q       <= hist_d;
            sample_cnt_q <= sample_cnt_d;
            bit_cnt_q    <= bit_cnt_d;
            shreg_q      <= shreg_d;
            par_bit_q    <= par_bit_d;
            par_acc_q    <= par_acc_d;
            fe_acc_q     <= fe_acc_d;
            rx_valid_q   <= rx_valid_d;
            data_out_q   <= data_out_d;
            parity_err_q <= parity_err_d;
            frame_err_q  <= frame_err_d;
            break_det_q  <= break_det_d;
            busy_q       <= busy_d;
        end
    end

    assign rx_valid   = rx_valid_q;
    assign data_out   = data_out_q;
    assign parity_err = parity_err_q;
    assign frame_err  = frame_err_q;
    assign break_det  = break_det_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_uart_rx_param.sv
// Directed bench for uart_rx_param: an 8N1 instance and an 8E1 instance
// sharing clock and reset, each with its own serial line.
module tb_uart_rx_param;
    logic       Bclk = 1'b0;
    logic       reset_n = 1'b0;
    logic       rx_a = 1'b1;
    logic       rx_p = 1'b1;

    logic       rx_valid_a, parity_err_a, frame_err_a, break_det_a, busy_a;
    logic [7:0] data_out_a;
    logic       rx_valid_p, parity_err_p, frame_err_p, break_det_p, busy_p;
    logic [7:0] data_out_p;

    int compared = 0;
    int mismatched = 0;
    int cyc = 0;
    int vcnt_a = 0, vcyc_a = 0;
    int vcnt_p = 0, vcyc_p = 0;
    int start_cyc = 0;
    int base_a = 0;

    uart_rx_param dut_a (
        .Bclk(Bclk), .reset_n(reset_n), .rx_data(rx_a),
        .rx_valid(rx_valid_a), .data_out(data_out_a), .parity_err(parity_err_a),
        .frame_err(frame_err_a), .break_det(break_det_a), .busy(busy_a)
    );

    uart_rx_param #(.OVERSAMPLE(16), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) dut_p (
        .Bclk(Bclk), .reset_n(reset_n), .rx_data(rx_p),
        .rx_valid(rx_valid_p), .data_out(data_out_p), .parity_err(parity_err_p),
        .frame_err(frame_err_p), .break_det(break_det_p), .busy(busy_p)
    );

    always #5 Bclk = ~Bclk;

    always @(posedge Bclk) cyc <= cyc + 1;

    always @(negedge Bclk) begin
        if (rx_valid_a) begin
            vcnt_a <= vcnt_a + 1;
            vcyc_a <= cyc;
        end
        if (rx_valid_p) begin
            vcnt_p <= vcnt_p + 1;
            vcyc_p <= cyc;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic ticks(input int n);
        repeat (n) @(posedge Bclk);
        #1;
    endtask

    task automatic set_line(input int sel, input logic v);
        if (sel == 0) rx_a = v;
        else rx_p = v;
    endtask

    // One frame, each bit 16 ticks; glitch_bit inverts tick 7 of that data bit
    task automatic send_frame(input int sel, input logic [7:0] d, input logic has_par,
                              input logic par_bit, input logic stop_v, input int glitch_bit);
        start_cyc = cyc;
        set_line(sel, 1'b0);
        ticks(16);
        check("busy_in_start", (sel == 0) ? busy_a : busy_p, 1);
        for (int i = 0; i < 8; i++) begin
            set_line(sel, d[i]);
            if (i == glitch_bit) begin
                ticks(7);
                set_line(sel, ~d[i]);
                ticks(1);
                set_line(sel, d[i]);
                ticks(8);
            end else begin
                ticks(16);
            end
        end
        if (has_par) begin
            set_line(sel, par_bit);
            ticks(16);
        end
        set_line(sel, stop_v);
        ticks(16);
        set_line(sel, 1'b1);
    endtask

    initial begin
        ticks(3);
        check("rst_valid", rx_valid_a, 0);
        check("rst_data", data_out_a, 8'h00);
        check("rst_perr", parity_err_a, 0);
        check("rst_ferr", frame_err_a, 0);
        check("rst_brk", break_det_a, 0);
        check("rst_busy", busy_a, 0);
        reset_n = 1'b1;
        ticks(4);

        // 8N1 0xA5 at exact baud
        send_frame(0, 8'hA5, 1'b0, 1'b0, 1'b1, -1);
        check("a5_count", vcnt_a, 1);
        check("a5_latency", vcyc_a - start_cyc, 155);
        check("a5_data", data_out_a, 8'hA5);
        check("a5_perr", parity_err_a, 0);
        check("a5_ferr", frame_err_a, 0);
        check("a5_brk", break_det_a, 0);
        check("a5_busy_after", busy_a, 0);

        // even parity: 0x3C needs parity bit 0
        send_frame(1, 8'h3C, 1'b1, 1'b1, 1'b1, -1);
        check("p_bad_count", vcnt_p, 1);
        check("p_bad_latency", vcyc_p - start_cyc, 171);
        check("p_bad_data", data_out_p, 8'h3C);
        check("p_bad_perr", parity_err_p, 1);
        check("p_bad_ferr", frame_err_p, 0);
        ticks(8);
        send_frame(1, 8'h3C, 1'b1, 1'b0, 1'b1, -1);
        check("p_good_count", vcnt_p, 2);
        check("p_good_data", data_out_p, 8'h3C);
        check("p_good_perr", parity_err_p, 0);

        // framing error, line stays low 3 more bit times
        ticks(8);
        send_frame(0, 8'h55, 1'b0, 1'b0, 1'b0, -1);
        rx_a = 1'b0;
        ticks(48);
        check("fe_count", vcnt_a, 2);
        check("fe_data", data_out_a, 8'h55);
        check("fe_ferr", frame_err_a, 1);
        check("fe_brk", break_det_a, 0);
        check("fe_busy_wait", busy_a, 1);
        rx_a = 1'b1;
        ticks(32);
        check("fe_no_extra", vcnt_a, 2);
        check("fe_busy_idle", busy_a, 0);
        send_frame(0, 8'h12, 1'b0, 1'b0, 1'b1, -1);
        check("fe_next_count", vcnt_a, 3);
        check("fe_next_data", data_out_a, 8'h12);
        check("fe_next_ferr", frame_err_a, 0);

        // break: line low for 12 bit times
        ticks(8);
        start_cyc = cyc;
        rx_a = 1'b0;
        ticks(192);
        rx_a = 1'b1;
        ticks(32);
        check("brk_count", vcnt_a, 4);
        check("brk_latency", vcyc_a - start_cyc, 155);
        check("brk_data", data_out_a, 8'h00);
        check("brk_ferr", frame_err_a, 1);
        check("brk_brk", break_det_a, 1);
        check("brk_busy", busy_a, 0);

        // 2-tick glitch on idle line
        rx_a = 1'b0;
        ticks(2);
        rx_a = 1'b1;
        ticks(3);
        check("glitch_busy_hi", busy_a, 1);
        ticks(20);
        check("glitch_busy_lo", busy_a, 0);
        check("glitch_count", vcnt_a, 4);
        check("glitch_brk_hold", break_det_a, 1);

        // single-tick inversion at bit-3 centre
        send_frame(0, 8'hF0, 1'b0, 1'b0, 1'b1, 3);
        check("f0_count", vcnt_a, 5);
        check("f0_data", data_out_a, 8'hF0);
        check("f0_ferr", frame_err_a, 0);
        check("f0_brk", break_det_a, 0);

        // back-to-back frames, then reset mid third frame
        ticks(8);
        base_a = vcnt_a;
        send_frame(0, 8'h81, 1'b0, 1'b0, 1'b1, -1);
        check("b2b1_count", vcnt_a, base_a + 1);
        check("b2b1_data", data_out_a, 8'h81);
        send_frame(0, 8'h7E, 1'b0, 1'b0, 1'b1, -1);
        check("b2b2_count", vcnt_a, base_a + 2);
        check("b2b2_latency", vcyc_a - start_cyc, 155);
        check("b2b2_data", data_out_a, 8'h7E);
        rx_a = 1'b0;
        ticks(16);
        rx_a = 1'b1;
        ticks(48);
        reset_n = 1'b0;
        #1;
        check("abort_busy", busy_a, 0);
        check("abort_data", data_out_a, 8'h00);
        check("abort_valid", rx_valid_a, 0);
        ticks(4);
        reset_n = 1'b1;
        ticks(200);
        check("abort_count", vcnt_a, base_a + 2);
        check("abort_data_after", data_out_a, 8'h00);
        check("abort_ferr", frame_err_a, 0);
        check("abort_brk", break_det_a, 0);
        check("abort_busy_after", busy_a, 0);
        check("abort_perr_p", parity_err_p, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
